// File: rtl/e203_ifu_bht_ctrl.sv
// IFU branch-history table controller: single-port 2-bit counter array shared
// between Bxx prediction lookups and a small queue of EXU outcome updates.
module e203_ifu_bht_ctrl #(
    parameter int PC_SIZE     = 32,
    parameter int BHT_IDX_W   = 6,
    parameter int UPD_Q_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bht_clr,
    output logic               init_done,
    input  logic               lkup_vld,
    input  logic [PC_SIZE-1:0] lkup_pc,
    output logic               lkup_rdy,
    output logic               lkup_rsp_vld,
    output logic               lkup_rsp_taken,
    input  logic               upd_vld,
    input  logic [PC_SIZE-1:0] upd_pc,
    input  logic               upd_taken,
    output logic               upd_rdy
);
    localparam int N     = 1 << BHT_IDX_W;
    localparam int QP_W  = $clog2(UPD_Q_DEPTH);
    localparam int CNT_W = QP_W + 1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic                 taken;
    } upd_t;

    state_e               state_q, state_d;
    logic [BHT_IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [1:0]           bht_q [N];
    logic [1:0]           bht_d [N];
    upd_t                 q_mem_q [UPD_Q_DEPTH];
    upd_t                 q_mem_d [UPD_Q_DEPTH];
    logic [QP_W-1:0]      q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
    logic [CNT_W-1:0]     q_cnt_q, q_cnt_d;
    logic                 lkup_rsp_vld_q, lkup_rsp_vld_d;
    logic                 lkup_rsp_taken_q, lkup_rsp_taken_d;

    logic                 run, q_full, q_empty;
    logic                 lkup_acc, push, pop;
    logic [BHT_IDX_W-1:0] lkup_idx, upd_idx;
    upd_t                 head;
    logic [1:0]           head_cnt;
    logic                 unused_pc_bits;

    // Halfword-granular index so RVC branches map to distinct entries.
    assign lkup_idx = lkup_pc[BHT_IDX_W:1];
    assign upd_idx  = upd_pc[BHT_IDX_W:1];
    assign unused_pc_bits = ^{lkup_pc[PC_SIZE-1:BHT_IDX_W+1], lkup_pc[0],
                              upd_pc[PC_SIZE-1:BHT_IDX_W+1], upd_pc[0]};

    assign run     = (state_q == S_RUN);
    assign q_full  = (q_cnt_q == CNT_W'(UPD_Q_DEPTH));
    assign q_empty = (q_cnt_q == '0);

    assign init_done      = run;
    assign lkup_rdy       = run & ~q_full;
    assign upd_rdy        = run & ~q_full;
    assign lkup_rsp_vld   = lkup_rsp_vld_q;
    assign lkup_rsp_taken = lkup_rsp_taken_q;

    assign lkup_acc = lkup_vld & lkup_rdy;
    assign push     = upd_vld & upd_rdy & ~bht_clr;
    // Lookups own the port; a full queue deasserts lkup_rdy so this drains.
    assign pop      = run & ~lkup_acc & ~q_empty;
    assign head     = q_mem_q[q_rptr_q];
    assign head_cnt = bht_q[head.idx];

    always_comb begin
        state_d          = state_q;
        init_ptr_d       = init_ptr_q;
        bht_d            = bht_q;
        q_mem_d          = q_mem_q;
        q_wptr_d         = q_wptr_q;
        q_rptr_d         = q_rptr_q;
        q_cnt_d          = q_cnt_q;
        lkup_rsp_vld_d   = 1'b0;
        lkup_rsp_taken_d = lkup_rsp_taken_q;

        if (state_q == S_INIT) begin
            bht_d[init_ptr_q] = 2'b01;
            if (bht_clr) begin
                init_ptr_d = '0;
            end else if (init_ptr_q == BHT_IDX_W'(N - 1)) begin
                state_d    = S_RUN;
                init_ptr_d = '0;
            end else begin
                init_ptr_d = init_ptr_q + BHT_IDX_W'(1);
            end
        end else begin
            if (lkup_acc) begin
                lkup_rsp_vld_d   = 1'b1;
                lkup_rsp_taken_d = bht_q[lkup_idx][1];
            end else if (pop) begin
                if (head.taken)
                    bht_d[head.idx] = (head_cnt == 2'd3) ? 2'd3 : head_cnt + 2'd1;
                else
                    bht_d[head.idx] = (head_cnt == 2'd0) ? 2'd0 : head_cnt - 2'd1;
            end
            if (bht_clr) begin
                state_d    = S_INIT;
                init_ptr_d = '0;
            end
        end

        if (run && bht_clr) begin
            q_wptr_d = '0;
            q_rptr_d = '0;
            q_cnt_d  = '0;
        end else begin
            if (push) begin
                q_mem_d[q_wptr_q] = '{idx: upd_idx, taken: upd_taken};
                q_wptr_d          = q_wptr_q + QP_W'(1);
            end
            if (pop)
                q_rptr_d = q_rptr_q + QP_W'(1);
            q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_INIT;
            init_ptr_q       <= '0;
            q_wptr_q         <= '0;
            q_rptr_q         <= '0;
            q_cnt_q          <= '0;
            lkup_rsp_vld_q   <= 1'b0;
            lkup_rsp_taken_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            init_ptr_q       <= init_ptr_d;
            q_wptr_q         <= q_wptr_d;
            q_rptr_q         <= q_rptr_d;
            q_cnt_q          <= q_cnt_d;
            lkup_rsp_vld_q   <= lkup_rsp_vld_d;
            lkup_rsp_taken_q <= lkup_rsp_taken_d;
        end
    end

    // Table and queue payload need no reset: INIT rewrites every entry and
    // queue slots are only read once the count says they hold data.
    always_ff @(posedge clk) begin
        bht_q   <= bht_d;
        q_mem_q <= q_mem_d;
    end

endmodule

// File: tb/tb_e203_ifu_bht_ctrl.sv
// Scoreboard bench for e203_ifu_bht_ctrl: directed test-plan sequences then
// random traffic, checked against a queue/array model of the BHT.
module tb_e203_ifu_bht_ctrl;
    localparam int N = 64;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst, bht_clr, lkup_vld, upd_vld, upd_taken;
    logic [31:0] lkup_pc, upd_pc;
    logic        init_done, lkup_rdy, lkup_rsp_vld, lkup_rsp_taken, upd_rdy;

    e203_ifu_bht_ctrl #(.PC_SIZE(32), .BHT_IDX_W(6), .UPD_Q_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .bht_clr(bht_clr), .init_done(init_done),
        .lkup_vld(lkup_vld), .lkup_pc(lkup_pc), .lkup_rdy(lkup_rdy),
        .lkup_rsp_vld(lkup_rsp_vld), .lkup_rsp_taken(lkup_rsp_taken),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_rdy(upd_rdy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: counter values as ints, pending updates in queues.
    int m_bht [N];
    bit m_run = 1'b0;
    int m_init_cnt = 0;
    int m_q_idx [$];
    bit m_q_tk [$];
    bit m_rsp_exp = 1'b0;
    bit m_prev_rst = 1'b0;
    bit sb [$];

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 1) % N);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (lkup_rsp_vld === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got response, expected none at %0t", $time);
            end else begin
                check("rsp_taken", {31'b0, lkup_rsp_taken}, {31'b0, sb.pop_front()});
            end
        end
    end

    task automatic model(bit r, bit c, bit lv, logic [31:0] lp, bit uv, logic [31:0] up, bit ut);
        bit rdy, la, ua;
        int i, v;
        if (r) begin
            m_run = 0; m_init_cnt = 0; m_rsp_exp = 0;
            m_q_idx.delete(); m_q_tk.delete();
        end else if (!m_run) begin
            m_rsp_exp = 0;
            if (c) m_init_cnt = 0;
            else begin
                m_init_cnt++;
                if (m_init_cnt == N) begin
                    m_run = 1;
                    foreach (m_bht[k]) m_bht[k] = 1;
                end
            end
        end else begin
            rdy = m_q_idx.size() < D;
            la = lv && rdy;
            ua = uv && rdy;
            m_rsp_exp = la;
            if (la) sb.push_back(m_bht[idx_of(lp)] >= 2);
            else if (m_q_idx.size() > 0) begin
                i = m_q_idx.pop_front();
                v = m_bht[i];
                if (m_q_tk.pop_front()) m_bht[i] = (v == 3) ? 3 : v + 1;
                else                    m_bht[i] = (v == 0) ? 0 : v - 1;
            end
            if (c) begin
                m_q_idx.delete(); m_q_tk.delete();
                m_run = 0; m_init_cnt = 0;
            end else if (ua) begin
                m_q_idx.push_back(idx_of(up));
                m_q_tk.push_back(ut);
            end
        end
        m_prev_rst = r;
    endtask

    task automatic step(bit r, bit c, bit lv, logic [31:0] lp, bit uv, logic [31:0] up, bit ut);
        @(negedge clk);
        check("init_done", {31'b0, init_done}, {31'b0, m_run});
        check("lkup_rdy", {31'b0, lkup_rdy}, {31'b0, m_run && m_q_idx.size() < D});
        check("upd_rdy", {31'b0, upd_rdy}, {31'b0, m_run && m_q_idx.size() < D});
        check("rsp_vld", {31'b0, lkup_rsp_vld}, {31'b0, m_rsp_exp});
        if (m_prev_rst) check("rst_rsp_taken", {31'b0, lkup_rsp_taken}, 32'd0);
        rst = r; bht_clr = c; lkup_vld = lv; lkup_pc = lp;
        upd_vld = uv; upd_pc = up; upd_taken = ut;
        model(r, c, lv, lp, uv, up, ut);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic lookup(logic [31:0] pc);
        step(0, 0, 1, pc, 0, 32'h0, 0);
        idle(1);
    endtask

    task automatic update(logic [31:0] pc, bit tk);
        step(0, 0, 0, 32'h0, 1, pc, tk);
        idle(1);
    endtask

    localparam logic [31:0] PA = 32'h8000_0010;
    localparam logic [31:0] PB = 32'h8000_0090;

    initial begin
        rst = 1; bht_clr = 0; lkup_vld = 0; upd_vld = 0; upd_taken = 0;
        lkup_pc = '0; upd_pc = '0;
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        idle(68);
        lookup(PA);                               // cold: weakly not-taken
        update(PA, 1); update(PA, 1); idle(2);
        lookup(PA);
        update(PA, 0); idle(1);
        lookup(PA);
        for (int i = 0; i < 5; i++) update(PA, 0);
        idle(1);
        lookup(PA);
        // Queue full under continuous lookup pressure.
        step(0, 0, 1, PA, 1, PB, 1);
        step(0, 0, 1, PA, 1, PB, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, PA, 0, 32'h0, 0);
        idle(4);
        update(PA, 1); update(PB, 1); idle(2);   // aliasing pair
        lookup(PA); lookup(PB);
        // bht_clr with two taken updates queued.
        step(0, 0, 1, PB, 1, PA, 1);
        step(0, 0, 1, PB, 1, PA, 1);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0);
        idle(66);
        lookup(PA);
        // Reset in the middle of INIT.
        step(0, 1, 0, 32'h0, 0, 32'h0, 0);
        idle(30);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        idle(66);
        lookup(PA);
        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] lp, up;
            lp = 32'h8000_0000 | ($urandom_range(0, 15) << 1) | ($urandom_range(0, 1) << 7) | $urandom_range(0, 1);
            up = 32'h8000_0000 | ($urandom_range(0, 15) << 1) | ($urandom_range(0, 1) << 7) | $urandom_range(0, 1);
            step($urandom_range(0, 999) == 0, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 1) == 1, lp, $urandom_range(0, 2) != 0, up,
                 $urandom_range(0, 1) == 1);
        end
        idle(3);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
